// File: rtl/sys_cmd_pkg.sv
// rtl/sys_cmd_pkg.sv - shared constants, state encoding and helpers for sys_cmd_ctrl
package sys_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int BYTE_W    = 8;
    localparam int ALU_RES_W = 2 * BYTE_W;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_FUN,
        ST_ALU_WAIT,
        ST_TX_RD,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

    // States in which the sequencer is collecting bytes of a frame.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
               (s == ST_OP_A)    || (s == ST_OP_B)    || (s == ST_FUN);
    endfunction

endpackage

// File: rtl/rx_byte_timer.sv
// rtl/rx_byte_timer.sv - inter-byte timeout down-counter
module rx_byte_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Reload whenever a byte is accepted or the frame is not in progress; otherwise count down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= LOAD;
        end else if (clear || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Expiry lasts one cycle because the sequencer leaves the receiving states on it.
    assign expire = en && (cnt == '0);

endmodule

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART command sequencer driving register file, ALU and transmitter
module sys_cmd_ctrl
    import sys_cmd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 4,
    parameter int OPA_ADDR    = 0,
    parameter int OPB_ADDR    = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx_valid,
    input  logic [WIDTH-1:0]   rx_data,
    input  logic               rx_frm_err,
    input  logic               rx_par_err,
    output logic               rf_wr_en,
    output logic               rf_rd_en,
    output logic [ADDR_W-1:0]  rf_addr,
    output logic [WIDTH-1:0]   rf_wr_data,
    input  logic [WIDTH-1:0]   rf_rd_data,
    input  logic               rf_rd_valid,
    output logic               alu_en,
    output logic [3:0]         alu_fun,
    output logic               alu_clk_en,
    input  logic [2*WIDTH-1:0] alu_out,
    input  logic               alu_out_valid,
    output logic [WIDTH-1:0]   tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [7:0]         err_cnt
);

    state_t              state, state_d;
    logic                wr_en_d, rd_en_d, alu_en_d, clk_en_d, tx_valid_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [WIDTH-1:0]    wdata_d, tx_data_d, res_hi, res_hi_d;
    logic [3:0]          fun_d;
    logic                err_inc, timer_clr, expire, rx_err;

    // An error pulse always wins over a byte arriving in the same cycle.
    assign rx_err = rx_frm_err || rx_par_err;

    rx_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (is_rx_state(state)),
        .clear   (timer_clr),
        .expire  (expire)
    );

    // State and every output register; outputs are loaded from the next-value logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            alu_clk_en <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_fun    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            res_hi     <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_d;
            rf_wr_en   <= wr_en_d;
            rf_rd_en   <= rd_en_d;
            alu_en     <= alu_en_d;
            alu_clk_en <= clk_en_d;
            rf_addr    <= addr_d;
            rf_wr_data <= wdata_d;
            alu_fun    <= fun_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            res_hi     <= res_hi_d;
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Next-state and next-output decode; strobes default low, data registers default to hold.
    always_comb begin
        state_d    = state;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        alu_en_d   = 1'b0;
        clk_en_d   = alu_clk_en;
        addr_d     = rf_addr;
        wdata_d    = rf_wr_data;
        fun_d      = alu_fun;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        res_hi_d   = res_hi;
        err_inc    = 1'b0;
        timer_clr  = 1'b0;

        if (is_rx_state(state) && (rx_err || (!rx_valid && expire))) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_err) begin
                        err_inc = 1'b1;
                    end else if (rx_valid) begin
                        timer_clr = 1'b1;
                        if (rx_data == WIDTH'(CMD_WR)) begin
                            state_d = ST_WR_ADDR;
                        end else if (rx_data == WIDTH'(CMD_RD)) begin
                            state_d = ST_RD_ADDR;
                        end else if (rx_data == WIDTH'(CMD_ALU_OP)) begin
                            state_d = ST_OP_A;
                        end else if (rx_data == WIDTH'(CMD_ALU_NOP)) begin
                            state_d = ST_FUN;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (rx_valid) begin
                        addr_d    = rx_data[ADDR_W-1:0];
                        timer_clr = 1'b1;
                        state_d   = ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_valid) begin
                        wdata_d = rx_data;
                        wr_en_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (rx_valid) begin
                        addr_d  = rx_data[ADDR_W-1:0];
                        rd_en_d = 1'b1;
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_OP_A, ST_OP_B: begin
                    if (rx_valid) begin
                        addr_d    = (state == ST_OP_A) ? ADDR_W'(OPA_ADDR) : ADDR_W'(OPB_ADDR);
                        wdata_d   = rx_data;
                        wr_en_d   = 1'b1;
                        timer_clr = 1'b1;
                        state_d   = (state == ST_OP_A) ? ST_OP_B : ST_FUN;
                    end
                end
                ST_FUN: begin
                    if (rx_valid) begin
                        fun_d    = rx_data[3:0];
                        alu_en_d = 1'b1;
                        clk_en_d = 1'b1;
                        state_d  = ST_ALU_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    err_inc = rx_valid || rx_err;
                    if (rf_rd_valid) begin
                        tx_data_d  = rf_rd_data;
                        tx_valid_d = 1'b1;
                        state_d    = ST_TX_RD;
                    end
                end
                ST_ALU_WAIT: begin
                    err_inc = rx_valid || rx_err;
                    if (alu_out_valid) begin
                        tx_data_d  = alu_out[WIDTH-1:0];
                        res_hi_d   = alu_out[2*WIDTH-1:WIDTH];
                        tx_valid_d = 1'b1;
                        clk_en_d   = 1'b0;
                        state_d    = ST_TX_LO;
                    end
                end
                ST_TX_RD, ST_TX_HI: begin
                    err_inc = rx_valid || rx_err;
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                ST_TX_LO: begin
                    err_inc = rx_valid || rx_err;
                    if (tx_ready) begin
                        tx_data_d = res_hi;
                        state_d   = ST_TX_HI;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command sequencer that sits behind the UART receiver and drives the system's register file, ALU and UART transmitter. It consumes received bytes (data plus framing/parity status), decodes fixed-format command frames and sequences register writes/reads and ALU operations. It then returns results to the transmitter over a valid/ready handshake. It is the single owner of the register-file and ALU control ports.

## Interface
- WIDTH, 8, data/byte width
- ADDR_W, 4, register-file address width; low ADDR_W bits of the address byte are used, upper bits ignored
- OPA_ADDR, 0, register address receiving ALU operand A
- OPB_ADDR, 1, register address receiving ALU operand B
- TIMEOUT_CYC, 4096, maximum clk cycles allowed between bytes of one frame

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- rx_valid  in  1  one-cycle pulse: rx_data holds a good byte
- rx_data  in  WIDTH  received byte
- rx_frm_err  in  1  framing error pulse from receiver
- rx_par_err  in  1  parity error pulse from receiver
- rf_wr_en  out  1  register write strobe, one cycle
- rf_rd_en  out  1  register read strobe, one cycle
- rf_addr  out  ADDR_W  register address
- rf_wr_data  out  WIDTH  register write data
- rf_rd_data  in  WIDTH  register read data
- rf_rd_valid  in  1  rf_rd_data valid, ≥1 cycle after rf_rd_en
- alu_en  out  1  ALU start strobe, one cycle
- alu_fun  out  4  ALU function, low 4 bits of function byte
- alu_clk_en  out  1  ALU clock-gate enable
- alu_out  in  2*WIDTH  ALU result
- alu_out_valid  in  1  alu_out valid, pulse
- tx_data  out  WIDTH  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- err_cnt  out  8  saturating count of dropped/aborted frames

## Operation
- Command codes: 0xAA addr data = write; 0xBB addr = read, reply 1 byte; 0xCC A B fun = write A→OPA_ADDR, B→OPB_ADDR, run ALU, reply 2 bytes; 0xDD fun = run ALU on stored operands, reply 2 bytes.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- IDLE: byte 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OP_A, 0xDD→FUN; any other byte dropped, err_cnt+1, stay IDLE.
- WR_ADDR latches addr → WR_DATA; on data byte, rf_wr_en pulse → IDLE.
- RD_ADDR: on addr byte, rf_rd_en pulse → RD_WAIT; on rf_rd_valid, latch rf_rd_data → TX_RD.
- OP_A / OP_B: each byte produces an rf_wr_en pulse to OPA_ADDR/OPB_ADDR → next state (OP_A→OP_B→FUN).
- FUN: on byte, alu_fun latched, alu_en pulse, alu_clk_en raised → ALU_WAIT; on alu_out_valid, latch result, drop alu_clk_en → TX_LO.
- TX_RD/TX_LO/TX_HI: tx_valid high, tx_data stable until tx_valid&tx_ready. TX_LO sends alu_out[WIDTH-1:0], then TX_HI sends the upper byte, then IDLE. TX_RD → IDLE.
- Abort: rx_frm_err or rx_par_err in any receiving state (WR_*, RD_ADDR, OP_*, FUN) → IDLE, err_cnt+1, no strobes issued. In IDLE the error pulse is counted only.
- Timeout: receiving states count cycles since last accepted byte; at TIMEOUT_CYC → IDLE, err_cnt+1.
- Overrun: rx_valid in RD_WAIT, ALU_WAIT or TX_* → byte dropped, err_cnt+1, state unaffected.
- Simultaneous rx_valid and error pulse: error wins, byte discarded.
- err_cnt saturates at 255.

## Timing
- All outputs are registered. Reset values: all strobes, tx_valid, alu_clk_en = 0; rf_addr, rf_wr_data, tx_data, alu_fun = 0; err_cnt = 0; state IDLE.
- Each strobe (rf_wr_en, rf_rd_en, alu_en) is asserted in the cycle after the triggering rx_valid, for exactly one cycle, with address/data valid in the same cycle.
- alu_clk_en rises together with alu_en and falls in the cycle after alu_out_valid.
- tx_valid rises in the cycle after rf_rd_valid/alu_out_valid. Back-to-back TX_LO→TX_HI with tx_ready held high: one byte per cycle.
- Reset mid-frame: immediate return to reset values; a partial frame has no effect.

## Structure
- Shared package sys_cmd_pkg: command-code constants (CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP), state enumeration, ALU result width constant.
- One sub-module: rx_byte_timer. It is a TIMEOUT_CYC down-counter with a clear on accepted byte, an enable while in receiving states, and a one-cycle expire output.

## Test plan
- Bytes AA 05 3C → one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; no tx_valid.
- Bytes BB 05, rf_rd_data=0x3C after 2 cycles → rf_rd_en at addr 5, then tx_data=0x3C; with tx_ready held low 10 cycles, tx_valid and tx_data stay stable.
- Bytes CC 0A 03 02, alu_out=0x001E after 3 cycles → writes 0x0A@0 and 0x03@1, alu_en with alu_fun=2, TX bytes 0x1E then 0x00; alu_clk_en high only during ALU_WAIT.
- Bytes AA 05 with rx_par_err on the third byte → no rf_wr_en, err_cnt=1, back in IDLE. Next AA 06 11 is written normally.
- Byte AA followed by TIMEOUT_CYC idle cycles → IDLE, err_cnt=1. Unknown byte 0x55 → err_cnt=2.
- reset_n pulsed low during ALU_WAIT → all outputs at reset values, alu_clk_en=0; a late alu_out_valid produces no tx_valid.
